// File: rtl/id_fwd_stage.sv
// Instruction-decode stage: RV32I/M decode, N-source priority operand
// forwarding, load-use scoreboard and a registered ID/EXE output with a
// valid/ready handshake toward EXE.
module id_fwd_stage #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned RADDR_WIDTH = 5,
  parameter int unsigned NUM_FWD     = 3,
  parameter int unsigned LOAD_LAT    = 1
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           inst_valid_i,
  output logic                           inst_ready_o,
  input  logic [31:0]                    inst_i,
  input  logic [ADDR_WIDTH-1:0]          inst_addr_i,
  output logic [RADDR_WIDTH-1:0]         reg1_raddr_o,
  output logic [RADDR_WIDTH-1:0]         reg2_raddr_o,
  output logic                           reg1_re_o,
  output logic                           reg2_re_o,
  input  logic [DATA_WIDTH-1:0]          reg1_rdata_i,
  input  logic [DATA_WIDTH-1:0]          reg2_rdata_i,
  input  logic [NUM_FWD-1:0]             fwd_we_i,
  input  logic [NUM_FWD*RADDR_WIDTH-1:0] fwd_waddr_i,
  input  logic [NUM_FWD*DATA_WIDTH-1:0]  fwd_wdata_i,
  input  logic                           flush_i,
  output logic                           exe_valid_o,
  input  logic                           exe_ready_i,
  output logic [31:0]                    inst_o,
  output logic [ADDR_WIDTH-1:0]          inst_addr_o,
  output logic [DATA_WIDTH-1:0]          op1_o,
  output logic [DATA_WIDTH-1:0]          op2_o,
  output logic                           reg_we_o,
  output logic [RADDR_WIDTH-1:0]         reg_waddr_o,
  output logic                           is_load_o,
  output logic                           illegal_o,
  output logic                           stallreq_o
);

  localparam int unsigned CNT_W    = (LOAD_LAT == 0) ? 1 : $clog2(LOAD_LAT + 1);
  localparam int unsigned NUM_REGS = 1 << RADDR_WIDTH;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  logic [RADDR_WIDTH-1:0] rs1, rs2, rd;
  logic [31:0]            imm_i, imm_u, imm_j;
  logic                   dec_re1, dec_re2, dec_we, dec_load, dec_illegal;
  logic [DATA_WIDTH-1:0]  dec_op1, dec_op2;
  logic [31:0]            dec_inst;
  logic                   hazard, out_free, fire_in, load_set;
  logic [CNT_W-1:0]       cnt [NUM_REGS];

  assign rs1   = RADDR_WIDTH'(inst_i[19:15]);
  assign rs2   = RADDR_WIDTH'(inst_i[24:20]);
  assign rd    = RADDR_WIDTH'(inst_i[11:7]);
  assign imm_i = {{20{inst_i[31]}}, inst_i[31:20]};
  assign imm_u = {inst_i[31:12], 12'b0};
  assign imm_j = {{12{inst_i[31]}}, inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};

  // Opcode decode: read enables, write enable and non-register operand values
  always_comb begin
    dec_re1     = 1'b0;
    dec_re2     = 1'b0;
    dec_we      = 1'b0;
    dec_load    = 1'b0;
    dec_illegal = 1'b0;
    dec_op1     = '0;
    dec_op2     = '0;
    dec_inst    = inst_i;
    case (inst_i[6:0])
      OP_IMM:   begin dec_re1 = 1'b1; dec_we = 1'b1; dec_op2 = DATA_WIDTH'($signed(imm_i)); end
      OP_REG:   begin dec_re1 = 1'b1; dec_re2 = 1'b1; dec_we = 1'b1; end
      OP_LUI:   begin dec_we = 1'b1; dec_op1 = DATA_WIDTH'(imm_u); end
      OP_AUIPC: begin dec_we = 1'b1; dec_op1 = DATA_WIDTH'(inst_addr_i); dec_op2 = DATA_WIDTH'(imm_u); end
      OP_STORE, OP_BRANCH: begin dec_re1 = 1'b1; dec_re2 = 1'b1; end
      OP_LOAD:  begin dec_re1 = 1'b1; dec_we = 1'b1; dec_load = 1'b1; dec_op2 = DATA_WIDTH'($signed(imm_i)); end
      OP_JAL:   begin dec_we = 1'b1; dec_op2 = DATA_WIDTH'($signed(imm_j)); end
      OP_JALR:  begin dec_re1 = 1'b1; dec_we = 1'b1; dec_op2 = DATA_WIDTH'($signed(imm_i)); end
      default:  begin dec_illegal = 1'b1; dec_inst = NOP; end
    endcase
  end

  // Operand resolution: x0/unused port -> decoded value, youngest forward, then regfile
  function automatic logic [DATA_WIDTH-1:0] sel_operand(
    input logic                   re,
    input logic [RADDR_WIDTH-1:0] raddr,
    input logic [DATA_WIDTH-1:0]  dec_val,
    input logic [DATA_WIDTH-1:0]  rdata
  );
    logic [DATA_WIDTH-1:0] val;
    logic                  found;
    val   = rdata;
    found = 1'b0;
    if (!re || raddr == '0) begin
      val = dec_val;
    end else begin
      for (int k = 0; k < int'(NUM_FWD); k++) begin
        if (!found && fwd_we_i[k] && fwd_waddr_i[k*RADDR_WIDTH +: RADDR_WIDTH] == raddr) begin
          val   = fwd_wdata_i[k*DATA_WIDTH +: DATA_WIDTH];
          found = 1'b1;
        end
      end
    end
    return val;
  endfunction

  assign reg1_re_o    = dec_re1;
  assign reg2_re_o    = dec_re2;
  assign reg1_raddr_o = dec_re1 ? rs1 : '0;
  assign reg2_raddr_o = dec_re2 ? rs2 : '0;

  assign hazard       = (dec_re1 && rs1 != '0 && cnt[rs1] != '0) ||
                        (dec_re2 && rs2 != '0 && cnt[rs2] != '0);
  assign stallreq_o   = inst_valid_i && hazard;
  assign out_free     = !exe_valid_o || exe_ready_i;
  assign inst_ready_o = !hazard && out_free && !flush_i;
  assign fire_in      = inst_valid_i && inst_ready_o;
  assign load_set     = exe_valid_o && exe_ready_i && is_load_o && reg_waddr_o != '0;

  // ID/EXE output register: flush beats capture, capture beats drain, else hold
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      exe_valid_o <= 1'b0;
      inst_o      <= NOP;
      inst_addr_o <= '0;
      op1_o       <= '0;
      op2_o       <= '0;
      reg_we_o    <= 1'b0;
      reg_waddr_o <= '0;
      is_load_o   <= 1'b0;
      illegal_o   <= 1'b0;
    end else if (flush_i) begin
      exe_valid_o <= 1'b0;
    end else if (fire_in) begin
      exe_valid_o <= 1'b1;
      inst_o      <= dec_inst;
      inst_addr_o <= inst_addr_i;
      op1_o       <= sel_operand(dec_re1, rs1, dec_op1, reg1_rdata_i);
      op2_o       <= sel_operand(dec_re2, rs2, dec_op2, reg2_rdata_i);
      reg_we_o    <= dec_we && rd != '0;
      reg_waddr_o <= dec_we ? rd : '0;
      is_load_o   <= dec_load;
      illegal_o   <= dec_illegal;
    end else if (exe_valid_o && exe_ready_i) begin
      exe_valid_o <= 1'b0;
    end
  end

  // Load scoreboard: a load accepted by EXE arms its rd counter; counters drain to 0
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(NUM_REGS); i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        if (load_set && reg_waddr_o == RADDR_WIDTH'(i)) cnt[i] <= CNT_W'(LOAD_LAT);
        else if (cnt[i] != '0) cnt[i] <= cnt[i] - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_id_fwd_stage.sv
// Directed bench for id_fwd_stage (LOAD_LAT=2, three forwarding sources).
module tb_id_fwd_stage;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        inst_valid_i;
  logic        inst_ready_o;
  logic [31:0] inst_i;
  logic [31:0] inst_addr_i;
  logic [4:0]  reg1_raddr_o, reg2_raddr_o;
  logic        reg1_re_o, reg2_re_o;
  logic [31:0] reg1_rdata_i, reg2_rdata_i;
  logic [2:0]  fwd_we_i;
  logic [14:0] fwd_waddr_i;
  logic [95:0] fwd_wdata_i;
  logic        flush_i;
  logic        exe_valid_o;
  logic        exe_ready_i;
  logic [31:0] inst_o, inst_addr_o, op1_o, op2_o;
  logic        reg_we_o;
  logic [4:0]  reg_waddr_o;
  logic        is_load_o, illegal_o, stallreq_o;

  int errors = 0;
  int checks = 0;

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] LW_X5  = 32'h0000_A283;  // lw   x5,0(x1)
  localparam logic [31:0] ADD_X6 = 32'h0072_8333;  // add  x6,x5,x7
  localparam logic [31:0] ADDI_4 = 32'h0011_8213;  // addi x4,x3,1
  localparam logic [31:0] LUI_X7 = 32'hABCD_E3B7;  // lui  x7,0xABCDE

  id_fwd_stage #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .RADDR_WIDTH(5), .NUM_FWD(3), .LOAD_LAT(2)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .inst_valid_i(inst_valid_i), .inst_ready_o(inst_ready_o),
    .inst_i(inst_i), .inst_addr_i(inst_addr_i),
    .reg1_raddr_o(reg1_raddr_o), .reg2_raddr_o(reg2_raddr_o),
    .reg1_re_o(reg1_re_o), .reg2_re_o(reg2_re_o),
    .reg1_rdata_i(reg1_rdata_i), .reg2_rdata_i(reg2_rdata_i),
    .fwd_we_i(fwd_we_i), .fwd_waddr_i(fwd_waddr_i), .fwd_wdata_i(fwd_wdata_i),
    .flush_i(flush_i),
    .exe_valid_o(exe_valid_o), .exe_ready_i(exe_ready_i),
    .inst_o(inst_o), .inst_addr_o(inst_addr_o),
    .op1_o(op1_o), .op2_o(op2_o),
    .reg_we_o(reg_we_o), .reg_waddr_o(reg_waddr_o),
    .is_load_o(is_load_o), .illegal_o(illegal_o),
    .stallreq_o(stallreq_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [2:0]  fwe;
    logic [14:0] fwa;
    logic [95:0] fwd;
    logic [1:0]  ere;     // {re2, re1}
    logic [31:0] einst;
    logic [31:0] eop1;
    logic [31:0] eop2;
    logic        ewe;
    logic [4:0]  ewa;
    logic        eld;
    logic        eill;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [159:0] got, input logic [159:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic idle();
    inst_valid_i = 1'b0;
    inst_i       = NOP;
    inst_addr_i  = '0;
    reg1_rdata_i = '0;
    reg2_rdata_i = '0;
    fwd_we_i     = '0;
    fwd_waddr_i  = '0;
    fwd_wdata_i  = '0;
    flush_i      = 1'b0;
    exe_ready_i  = 1'b1;
  endtask

  // Two reset edges; returns at a negedge with reset released.
  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b1;
    idle();
    @(posedge clk_i);
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  function automatic logic [159:0] out_bus();
    return {23'b0, exe_valid_o, inst_o, inst_addr_o, op1_o, op2_o,
            reg_we_o, reg_waddr_o, is_load_o, illegal_o};
  endfunction

  // Capture lw x5 and let EXE accept it; returns at a negedge with cnt[5]=2.
  task automatic load_x5_and_accept();
    inst_i = LW_X5; inst_valid_i = 1'b1; exe_ready_i = 1'b1;
    @(posedge clk_i); #1;
    chk("lw_capture", {157'b0, exe_valid_o, is_load_o, reg_we_o}, {157'b0, 3'b111});
    @(negedge clk_i);
    inst_valid_i = 1'b0;
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  initial begin
    int n;
    rst_i = 1'b1;
    idle();

    // Reset values
    do_reset();
    #1;
    chk("reset_outputs", out_bus(), {23'b0, 1'b0, NOP, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0});
    chk("reset_stall", {159'b0, stallreq_o}, 160'd0);

    // Directed decode/forwarding vectors
    vecs.push_back('{32'h00118213, 32'h100, 32'h77, 32'h0, 3'b111, {5'd3,5'd3,5'd3}, {32'hC,32'hB,32'hA},
                     2'b01, 32'h00118213, 32'hA, 32'h1, 1'b1, 5'd4, 1'b0, 1'b0});
    vecs.push_back('{32'hFFF08113, 32'h104, 32'h100, 32'h999, 3'b000, 15'd0, 96'd0,
                     2'b01, 32'hFFF08113, 32'h100, 32'hFFFFFFFF, 1'b1, 5'd2, 1'b0, 1'b0});
    vecs.push_back('{32'h000000B3, 32'h108, 32'h55, 32'h66, 3'b001, 15'd0, {32'h0,32'h0,32'hDEAD},
                     2'b11, 32'h000000B3, 32'h0, 32'h0, 1'b1, 5'd1, 1'b0, 1'b0});
    vecs.push_back('{32'h003100B3, 32'h10C, 32'h11, 32'h22, 3'b110, {5'd2,5'd3,5'd2}, {32'h44,32'h33,32'hDEAD},
                     2'b11, 32'h003100B3, 32'h44, 32'h33, 1'b1, 5'd1, 1'b0, 1'b0});
    vecs.push_back('{32'h12345037, 32'h110, 32'h1, 32'h2, 3'b000, 15'd0, 96'd0,
                     2'b00, 32'h12345037, 32'h12345000, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0});
    vecs.push_back('{32'hABCDE3B7, 32'h114, 32'h1, 32'h2, 3'b000, 15'd0, 96'd0,
                     2'b00, 32'hABCDE3B7, 32'hABCDE000, 32'h0, 1'b1, 5'd7, 1'b0, 1'b0});
    vecs.push_back('{32'h00001417, 32'h80000100, 32'h1, 32'h2, 3'b000, 15'd0, 96'd0,
                     2'b00, 32'h00001417, 32'h80000100, 32'h1000, 1'b1, 5'd8, 1'b0, 1'b0});
    vecs.push_back('{32'h00208423, 32'h11C, 32'h1000, 32'h2222, 3'b000, 15'd0, 96'd0,
                     2'b11, 32'h00208423, 32'h1000, 32'h2222, 1'b0, 5'd0, 1'b0, 1'b0});
    vecs.push_back('{32'h00208063, 32'h120, 32'h5, 32'h6, 3'b000, 15'd0, 96'd0,
                     2'b11, 32'h00208063, 32'h5, 32'h6, 1'b0, 5'd0, 1'b0, 1'b0});
    vecs.push_back('{32'h008000EF, 32'h124, 32'h9, 32'h9, 3'b000, 15'd0, 96'd0,
                     2'b00, 32'h008000EF, 32'h0, 32'h8, 1'b1, 5'd1, 1'b0, 1'b0});
    vecs.push_back('{32'hFFDFF0EF, 32'h128, 32'h9, 32'h9, 3'b000, 15'd0, 96'd0,
                     2'b00, 32'hFFDFF0EF, 32'h0, 32'hFFFFFFFC, 1'b1, 5'd1, 1'b0, 1'b0});
    vecs.push_back('{32'h004280E7, 32'h12C, 32'h2000, 32'h9, 3'b000, 15'd0, 96'd0,
                     2'b01, 32'h004280E7, 32'h2000, 32'h4, 1'b1, 5'd1, 1'b0, 1'b0});
    vecs.push_back('{32'h1234507F, 32'h130, 32'h9, 32'h9, 3'b000, 15'd0, 96'd0,
                     2'b00, NOP, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b1});
    vecs.push_back('{32'h00C52483, 32'h134, 32'h300, 32'h9, 3'b000, 15'd0, 96'd0,
                     2'b01, 32'h00C52483, 32'h300, 32'hC, 1'b1, 5'd9, 1'b1, 1'b0});

    foreach (vecs[i]) begin
      inst_i = vecs[i].inst; inst_addr_i = vecs[i].pc;
      reg1_rdata_i = vecs[i].rd1; reg2_rdata_i = vecs[i].rd2;
      fwd_we_i = vecs[i].fwe; fwd_waddr_i = vecs[i].fwa; fwd_wdata_i = vecs[i].fwd;
      inst_valid_i = 1'b1; exe_ready_i = 1'b1;
      #1;
      chk($sformatf("vec%0d_re_ready", i), {157'b0, reg2_re_o, reg1_re_o, inst_ready_o},
          {157'b0, vecs[i].ere, 1'b1});
      @(posedge clk_i); #1;
      chk($sformatf("vec%0d_out", i), out_bus(),
          {23'b0, 1'b1, vecs[i].einst, vecs[i].pc, vecs[i].eop1, vecs[i].eop2,
           vecs[i].ewe, vecs[i].ewa, vecs[i].eld, vecs[i].eill});
      @(negedge clk_i);
    end

    // Load-use: add x6,x5,x7 stalls two cycles, then takes x5 from fwd source 1
    do_reset();
    load_x5_and_accept();
    inst_i = ADD_X6; inst_valid_i = 1'b1; reg1_rdata_i = 32'h1111; reg2_rdata_i = 32'h7777;
    fwd_we_i = 3'b010; fwd_waddr_i = {5'd0, 5'd5, 5'd0}; fwd_wdata_i = {32'h0, 32'h5A5A, 32'h0};
    n = 0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (!stallreq_o) break;
      n++;
      @(negedge clk_i);
    end
    chk("load_use_stall_cycles", 160'(n), 160'd2);
    chk("load_use_ready_after", {159'b0, inst_ready_o}, 160'd1);
    @(posedge clk_i); #1;
    chk("load_use_fire", {90'b0, exe_valid_o, op1_o, op2_o, reg_waddr_o},
        {90'b0, 1'b1, 32'h5A5A, 32'h7777, 5'd6});
    @(negedge clk_i);

    // Back-pressure: EXE stalls 3 cycles, outputs hold, then next instruction enters
    do_reset();
    inst_i = ADDI_4; reg1_rdata_i = 32'h10; inst_valid_i = 1'b1; exe_ready_i = 1'b1;
    @(posedge clk_i); @(negedge clk_i);
    inst_i = LUI_X7; exe_ready_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("bp%0d_ready", c), {159'b0, inst_ready_o}, 160'd0);
      @(posedge clk_i); #1;
      chk($sformatf("bp%0d_hold", c), {63'b0, exe_valid_o, inst_o, op1_o, op2_o},
          {63'b0, 1'b1, ADDI_4, 32'h10, 32'h1});
      @(negedge clk_i);
    end
    exe_ready_i = 1'b1;
    #1;
    chk("bp_release_ready", {159'b0, inst_ready_o}, 160'd1);
    @(posedge clk_i); #1;
    chk("bp_release_capture", {95'b0, exe_valid_o, inst_o, op1_o}, {95'b0, 1'b1, LUI_X7, 32'hABCDE000});
    @(negedge clk_i);

    // Flush during a load-use stall: output invalidated, scoreboard keeps counting
    do_reset();
    inst_i = LW_X5; inst_valid_i = 1'b1; exe_ready_i = 1'b1;
    @(posedge clk_i); @(negedge clk_i);
    inst_i = ADDI_4; reg1_rdata_i = 32'h10;
    @(posedge clk_i); @(negedge clk_i);
    inst_i = ADD_X6; exe_ready_i = 1'b0; flush_i = 1'b1;
    #1;
    chk("flush_stall_before", {158'b0, stallreq_o, inst_ready_o}, {158'b0, 2'b10});
    @(posedge clk_i); #1;
    chk("flush_valid_cleared", {159'b0, exe_valid_o}, 160'd0);
    @(negedge clk_i);
    flush_i = 1'b0;
    #1;
    chk("flush_scoreboard_kept", {159'b0, stallreq_o}, 160'd1);
    @(posedge clk_i); @(negedge clk_i);
    #1;
    chk("flush_scoreboard_drained", {158'b0, stallreq_o, inst_ready_o}, {158'b0, 2'b01});
    exe_ready_i = 1'b1;
    @(posedge clk_i); #1;
    chk("flush_then_fire", {127'b0, exe_valid_o, inst_o}, {127'b0, 1'b1, ADD_X6});
    @(negedge clk_i);

    // Reset mid-stall clears scoreboard and output register
    do_reset();
    load_x5_and_accept();
    inst_i = ADD_X6; inst_valid_i = 1'b1;
    #1;
    chk("rst_midstall_before", {159'b0, stallreq_o}, 160'd1);
    rst_i = 1'b1;
    @(posedge clk_i); @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    chk("rst_midstall_after", {126'b0, stallreq_o, exe_valid_o, inst_o}, {126'b0, 1'b0, 1'b0, NOP});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
